// File: rtl/led_array_pkg.sv
// rtl/led_array_pkg.sv - shared mode encoding and defaults for the LED array
package led_array_pkg;

    // Per-channel mode codes as they appear on the Mode bus
    typedef enum logic [1:0] {
        LED_ACT   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_OFF   = 2'b11
    } LED_MODE_t;

    localparam int PWM_BITS_DEFAULT = 4;

endpackage

// File: rtl/led_array_ch.sv
// rtl/led_array_ch.sv - one LED channel: hold counter, mode decode, PWM gate, output register
module led_array_ch
    import led_array_pkg::*;
#(
    parameter int DELAY      = 21_480_000,
    parameter int PWM_BITS   = PWM_BITS_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  LED_MODE_t           mode_i,
    input  logic                trigger_i,
    input  logic [PWM_BITS-1:0] bright_i,
    input  logic [PWM_BITS-1:0] pwm_i,
    input  logic                blink_on_i,
    output logic                led_o
);

    localparam int HW = $clog2(DELAY + 1);

    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          lit;
    logic          gated;
    logic          led_q;

    // Hold counter next state: OFF clears and wins over trigger, trigger reloads, else count down
    always_comb begin
        hold_d = hold_q;
        if (mode_i == LED_OFF) begin
            hold_d = '0;
        end else if (trigger_i) begin
            hold_d = HW'(DELAY);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end
    end

    // Raw lit decode; ACT looks at the live trigger so the first lit cycle has no extra latency
    always_comb begin
        lit = 1'b0;
        case (mode_i)
            LED_ACT:   lit = trigger_i | (hold_q != '0);
            LED_ON:    lit = 1'b1;
            LED_BLINK: lit = blink_on_i;
            LED_OFF:   lit = 1'b0;
            default:   lit = 1'b0;
        endcase
    end

    // Brightness gate; all-ones bypasses the compare so full scale is truly 100 %
    always_comb begin
        gated = lit & ((&bright_i) | (pwm_i < bright_i));
    end

    // Hold counter and output register; reset parks the pin at its inactive level
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_q <= '0;
            led_q  <= ACTIVE_LOW;
        end else begin
            hold_q <= hold_d;
            led_q  <= gated ^ ACTIVE_LOW;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_array.sv
// rtl/led_array.sv - multi-channel LED driver with afterglow, blink and PWM dimming
module led_array
    import led_array_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DELAY      = 21_480_000,
    parameter int BLINK      = 2_148_000,
    parameter int PWM_BITS   = PWM_BITS_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [2*NUM_CH-1:0]        Mode,
    input  logic [NUM_CH-1:0]          Trigger,
    input  logic [PWM_BITS*NUM_CH-1:0] Bright,
    output logic [NUM_CH-1:0]          LedPort
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("led_array: NUM_CH must be in 1..16");
    end
    if (DELAY < 1) begin : g_bad_delay
        $error("led_array: DELAY must be at least 1");
    end
    if (BLINK < 2 || (BLINK % 2) != 0) begin : g_bad_blink
        $error("led_array: BLINK must be even and at least 2");
    end
    if (PWM_BITS < 1 || PWM_BITS > 8) begin : g_bad_pwm_bits
        $error("led_array: PWM_BITS must be in 1..8");
    end

    localparam int BW = $clog2(BLINK);

    logic [BW-1:0]       blink_q;
    logic [BW-1:0]       blink_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] pwm_d;
    logic                any_blink;
    logic                blink_on;

    // Detect whether any channel currently wants the shared blink timebase
    always_comb begin
        any_blink = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Mode[2*i +: 2] == LED_BLINK) begin
                any_blink = 1'b1;
            end
        end
    end

    // Blink counter parks at 0 when idle so a newly blinking LED always starts in the lit half
    always_comb begin
        blink_d = blink_q;
        if (!any_blink) begin
            blink_d = '0;
        end else if (blink_q == BW'(BLINK - 1)) begin
            blink_d = '0;
        end else begin
            blink_d = blink_q + BW'(1);
        end
        pwm_d    = pwm_q + PWM_BITS'(1);
        blink_on = (blink_q < BW'(BLINK / 2));
    end

    // Shared timebases
    always_ff @(posedge CLK) begin
        if (RESET) begin
            blink_q <= '0;
            pwm_q   <= '0;
        end else begin
            blink_q <= blink_d;
            pwm_q   <= pwm_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_array_ch #(
            .DELAY      (DELAY),
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk_i      (CLK),
            .reset_i    (RESET),
            .mode_i     (LED_MODE_t'(Mode[2*i +: 2])),
            .trigger_i  (Trigger[i]),
            .bright_i   (Bright[PWM_BITS*i +: PWM_BITS]),
            .pwm_i      (pwm_q),
            .blink_on_i (blink_on),
            .led_o      (LedPort[i])
        );
    end

endmodule

// File: tb/tb_led_array.sv
// tb/tb_led_array.sv - scoreboard bench for led_array, active-high and active-low instances
module tb_led_array;
    import led_array_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] mode;
    logic [3:0] trig;
    logic [7:0] bright;
    logic [3:0] led0;
    logic [3:0] led1;

    int compared = 0;
    int mismatched = 0;
    int n = 0;

    logic [3:0] exp_q[$];
    string      name_q[$];

    always #5 CLK = ~CLK;

    led_array #(
        .NUM_CH(4), .DELAY(8), .BLINK(10), .PWM_BITS(2), .ACTIVE_LOW(1'b0)
    ) dut0 (
        .CLK(CLK), .RESET(RESET), .Mode(mode), .Trigger(trig), .Bright(bright), .LedPort(led0)
    );

    led_array #(
        .NUM_CH(4), .DELAY(8), .BLINK(10), .PWM_BITS(2), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .CLK(CLK), .RESET(RESET), .Mode(mode), .Trigger(trig), .Bright(bright), .LedPort(led1)
    );

    task automatic set_mode(input int ch, input LED_MODE_t m);
        mode[2*ch +: 2] = m;
    endtask

    // Called at a negedge with inputs already set: queue what the next posedge must produce
    task automatic step(input string nm, input logic [3:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge CLK);
        if (RESET) n = 0;
        else n++;
    endtask

    // Monitor: one expected vector per clock edge, checked just after the edge
    always @(posedge CLK) begin
        logic [3:0] e;
        string      nm;
        #1;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            compared++;
            if (led0 !== e) begin
                mismatched++;
                $display("FAIL %s (high-true): LedPort=%b expected %b at %0t", nm, led0, e, $time);
            end
            compared++;
            if (led1 !== ~e) begin
                mismatched++;
                $display("FAIL %s (low-true): LedPort=%b expected %b at %0t", nm, led1, ~e, $time);
            end
        end
    end

    initial begin
        mode   = 8'hFF;
        trig   = 4'b0000;
        bright = 8'hFF;
        RESET  = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) step("reset", 4'b0000);
        RESET = 1'b0;

        // Single-cycle trigger: DELAY+1 = 9 lit cycles
        set_mode(0, LED_ACT);
        step("act_idle", 4'b0000);
        trig[0] = 1'b1;
        step("act_trig", 4'b0001);
        trig[0] = 1'b0;
        for (int k = 0; k < 8; k++) step("act_glow", 4'b0001);
        for (int k = 0; k < 3; k++) step("act_dark", 4'b0000);

        // Retrigger exactly when hold = 1
        trig[0] = 1'b1;
        step("retrig_first", 4'b0001);
        trig[0] = 1'b0;
        for (int k = 0; k < 7; k++) step("retrig_glow", 4'b0001);
        trig[0] = 1'b1;
        step("retrig_at_hold1", 4'b0001);
        trig[0] = 1'b0;
        for (int k = 0; k < 8; k++) step("retrig_glow2", 4'b0001);
        for (int k = 0; k < 2; k++) step("retrig_dark", 4'b0000);

        // Blink from idle: 5 high, 5 low
        set_mode(1, LED_BLINK);
        for (int k = 0; k < 20; k++) step("blink", ((k % 10) < 5) ? 4'b0010 : 4'b0000);
        set_mode(1, LED_OFF);
        step("blink_off", 4'b0000);
        step("blink_off", 4'b0000);
        set_mode(1, LED_BLINK);
        step("blink_restart", 4'b0010);
        set_mode(1, LED_OFF);
        step("blink_off2", 4'b0000);

        // Steady ON with dimming; n is the pwm value seen at the upcoming edge
        set_mode(2, LED_ON);
        bright[5:4] = 2'd1;
        for (int k = 0; k < 8; k++) step("pwm_b1", ((n % 4) == 0) ? 4'b0100 : 4'b0000);
        bright[5:4] = 2'd0;
        for (int k = 0; k < 4; k++) step("pwm_b0", 4'b0000);
        bright[5:4] = 2'd2;
        for (int k = 0; k < 4; k++) step("pwm_b2", ((n % 4) < 2) ? 4'b0100 : 4'b0000);
        bright[5:4] = 2'd3;
        for (int k = 0; k < 4; k++) step("pwm_b3", 4'b0100);
        set_mode(2, LED_OFF);
        step("on_to_off", 4'b0000);

        // OFF beats trigger; hold stays empty when moving to ACT
        set_mode(3, LED_OFF);
        trig[3] = 1'b1;
        for (int k = 0; k < 3; k++) step("off_trig", 4'b0000);
        set_mode(3, LED_ACT);
        trig[3] = 1'b0;
        for (int k = 0; k < 3; k++) step("off_to_act", 4'b0000);
        set_mode(3, LED_OFF);

        // Reset mid-afterglow and mid-blink, then restart from scratch
        set_mode(1, LED_BLINK);
        trig[0] = 1'b1;
        step("pre_reset_trig", 4'b0011);
        trig[0] = 1'b0;
        for (int k = 0; k < 2; k++) step("pre_reset_glow", 4'b0011);
        RESET = 1'b1;
        for (int k = 0; k < 2; k++) step("mid_reset", 4'b0000);
        RESET = 1'b0;
        step("post_reset_idle", 4'b0010);
        trig[0] = 1'b1;
        step("post_reset_trig", 4'b0011);
        trig[0] = 1'b0;
        for (int b = 2; b <= 9; b++)
            step("post_reset_glow", {2'b00, ((b % 10) < 5), 1'b1});
        for (int b = 10; b <= 11; b++)
            step("post_reset_dark", {2'b00, ((b % 10) < 5), 1'b0});

        mode = 8'hFF;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
